// File: rtl/uart_pkg_d.sv
// rtl/uart_pkg_d.sv - shared UART types, constants and helper functions
package uart_pkg_d;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    RESULT
  } rx_state_t;

  // Even parity: the parity bit equals the XOR of all data bits.
  function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction

  // Oversample prescaler divisor, rounded down.
  function automatic int calc_div(input int clk_freq, input int baud, input int os);
    return clk_freq / (baud * os);
  endfunction

endpackage

// File: rtl/receiver_d_baudgen.sv
// rtl/receiver_d_baudgen.sv - oversample prescaler with synchronous clear
module BaudGenOS_d #(
  parameter int DIV = 27
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic baud_tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  // Count 0..DIV-1; clear realigns the tick phase to a start edge.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (cnt == CW'(DIV - 1)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign baud_tick = (cnt == CW'(DIV - 1));

endmodule

// File: rtl/receiver_d.sv
// rtl/receiver_d.sv - UART receiver, 8E1 frames, 16x oversampled mid-bit sampling
module receiver_d
  import uart_pkg_d::*;
#(
  parameter int CLK_FREQ    = 50_000_000,
  parameter int BAUD        = 115200,
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 data_rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 parity_error,
  output logic                 framing_error,
  output logic                 active_flag,
  output logic                 done_flag
);

  localparam int DIV   = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int SW    = $clog2(OVERSAMPLE);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [SW-1:0] MID = SW'(OVERSAMPLE / 2 - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] fill_q;
  logic                   rx_s;
  logic                   fill_done;
  logic                   rx_prev;
  logic                   arm_ok;
  logic                   start_edge;
  logic                   tick;
  logic                   mid_tick;
  logic [SW-1:0]          s_cnt;
  logic [IDX_W-1:0]       bit_idx;
  logic [DATA_BITS-1:0]   shift_q;
  logic                   p_rx;
  rx_state_t              state;
  rx_state_t              state_nx;

  // Synchroniser; fill_q marks when the chain holds only real line samples.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q <= '1;
      fill_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], data_rx};
      fill_q <= {fill_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign rx_s      = sync_q[SYNC_STAGES-1];
  assign fill_done = fill_q[SYNC_STAGES-1];

  // Edge history and arming: a start is only accepted after a genuine idle high.
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_prev <= 1'b1;
      arm_ok  <= 1'b0;
    end else begin
      rx_prev <= rx_s;
      if (state == STOP && mid_tick && !rx_s) begin
        arm_ok <= 1'b0;
      end else if (fill_done && rx_s) begin
        arm_ok <= 1'b1;
      end
    end
  end

  assign start_edge = (state == IDLE) && arm_ok && rx_prev && !rx_s;

  BaudGenOS_d #(
    .DIV(DIV)
  ) u_baudgen (
    .clock    (clock),
    .reset    (reset),
    .clear    (start_edge),
    .baud_tick(tick)
  );

  // Sample counter wraps every bit; mid-bit is a fixed phase after the start edge.
  always_ff @(posedge clock) begin
    if (reset || start_edge) begin
      s_cnt <= '0;
    end else if (tick) begin
      s_cnt <= s_cnt + 1'b1;
    end
  end

  assign mid_tick = tick && (s_cnt == MID);

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state and status outputs.
  always_comb begin
    state_nx    = state;
    data_valid  = 1'b0;
    done_flag   = 1'b0;
    active_flag = 1'b0;
    case (state)
      IDLE: begin
        if (start_edge) state_nx = START;
      end
      START: begin
        active_flag = 1'b1;
        if (mid_tick) state_nx = rx_s ? IDLE : DATA;
      end
      DATA: begin
        active_flag = 1'b1;
        if (mid_tick && bit_idx == IDX_W'(DATA_BITS - 1)) state_nx = PARITY;
      end
      PARITY: begin
        active_flag = 1'b1;
        if (mid_tick) state_nx = STOP;
      end
      STOP: begin
        active_flag = 1'b1;
        if (mid_tick) state_nx = RESULT;
      end
      RESULT: begin
        data_valid = 1'b1;
        done_flag  = 1'b1;
        state_nx   = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: shift data LSB first, capture parity, publish result at the stop sample.
  always_ff @(posedge clock) begin
    if (reset) begin
      bit_idx       <= '0;
      shift_q       <= '0;
      p_rx          <= 1'b0;
      data_out      <= '0;
      parity_error  <= 1'b0;
      framing_error <= 1'b0;
    end else if (mid_tick) begin
      case (state)
        START:  bit_idx <= '0;
        DATA: begin
          shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
          bit_idx <= bit_idx + 1'b1;
        end
        PARITY: p_rx <= rx_s;
        STOP: begin
          data_out      <= shift_q;
          parity_error  <= (p_rx != even_parity(shift_q));
          framing_error <= !rx_s;
        end
        default: ;
      endcase
    end
  end

endmodule
